alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage ALU that directly consumes the 4-bit ALUControl code from the ALU decoder, plus the two source operands.
- Computes the result and branch flags, then holds them in a single-entry registered output stage.
- Uses valid/ready handshakes on both sides and a flush input, so the hazard unit can stall or kill the execute stage.
- Sits between the ID/EX operand mux and the EX/MEM consumer.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- ALU_CTRL_WIDTH, 4, width of ALUControl.
- SHAMT_WIDTH, 5, low bits of SrcB used as shift amount; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and ALUControl valid this cycle.
- in_ready  output  1  stage can accept an operation this cycle.
- ALUControl  input  ALU_CTRL_WIDTH  operation code from the ALU decoder.
- SrcA  input  DATA_WIDTH  operand A (register value, or PC for codes 1010/1100).
- SrcB  input  DATA_WIDTH  operand B (register value or immediate).
- flush  input  1  kill the held result and any capture this cycle.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts the result.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  registered (ALUResult == 0).
- LtS  output  1  registered signed SrcA < SrcB.
- LtU  output  1  registered unsigned SrcA < SrcB.
- illegal  output  1  registered: captured ALUControl was undefined.

Behaviour:
- ALUControl encodings (the ALU decoder is required to emit exactly these):
  - 0000 add: A+B, mod 2^DATA_WIDTH.
  - 0001 sub: A-B.
  - 0010 sll: A << B[SHAMT_WIDTH-1:0].
  - 0011 slt: {0…, signed A<B}.
  - 0100 sltu: {0…, unsigned A<B}.
  - 0101 xor: A^B.
  - 0110 srl: logical right shift.
  - 0111 sra: arithmetic right shift, sign bit of A replicated.
  - 1000 or: A|B.
  - 1001 and: A&B.
  - 1010 auipc: A+B, with A = PC and B = U-immediate.
  - 1011 lui: result = B.
  - 1100 jal/jalr link: result = A+4.
  - 1101–1111: result 0, illegal=1.
- Shifts ignore B bits above SHAMT_WIDTH-1.
- LtS and LtU are computed from the operands for every code, independent of the result. Zero is computed from the result.
- Handshake:
  - Capture when in_valid && in_ready && !flush.
  - in_ready = !out_valid || out_ready. This is combinational and permits back-to-back throughput of one operation per cycle.
  - Latency: 1 cycle from capture to out_valid=1.
  - out_valid and all result fields hold stable while out_valid && !out_ready.
  - Transfer out occurs when out_valid && out_ready. If there is no simultaneous capture, out_valid deasserts on the next edge.
  - Simultaneous out-transfer and in-capture: the new result replaces the old one and out_valid stays 1.
- State machine: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on capture.
  - FULL -> FULL on (out_ready && capture) or !out_ready.
  - FULL -> EMPTY on out_ready && !capture.
  - Any state -> EMPTY on flush.
- Flush:
  - Synchronous. The next edge forces out_valid=0 regardless of in_valid or out_ready, and the input that cycle is discarded.
  - in_ready is still driven per the rule above during flush, but no capture occurs.
- Reset (asynchronous, active-low): out_valid=0, ALUResult=0, Zero=0, LtS=0, LtU=0, illegal=0.
  - Reset mid-operation discards any held result.
  - in_ready=1 after reset.
- Result registers update only on capture; they are not cleared on flush.

Test Plan:
- Reset, then in_valid=1, ALUControl=0001, SrcA=5, SrcB=5 -> next cycle out_valid=1, ALUResult=0, Zero=1, LtS=0, LtU=0.
- ALUControl=0111, SrcA=0x80000000, SrcB=0x00000024 (shamt 4) -> ALUResult=0xF8000000. ALUControl=0110 with the same operands -> ALUResult=0x08000000.
- ALUControl=0011 and then 0100, SrcA=0xFFFFFFFF, SrcB=1 -> slt ALUResult=1, LtS=1; sltu ALUResult=0, LtU=0.
- Back-pressure: hold out_ready=0 for 3 cycles after capturing add 2+3 -> ALUResult stays 5, in_ready=0. Raise out_ready with a new 1011 op (SrcB=0x12345000) -> the next cycle shows 0x12345000 and out_valid stays 1.
- Flush: capture 1100 with SrcA=0x100, then assert flush with in_valid=1 -> out_valid=0 on the next edge and no result appears for the flushed input.
- Assert ALUControl=1110 -> ALUResult=0, illegal=1. Assert rst_n=0 asynchronously mid-FULL -> out_valid and illegal drop immediately.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a single-entry registered output buffer.
// Valid/ready on both sides; flush kills the held result and any same-cycle capture.
module alu_exec_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int SHAMT_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    input  logic [DATA_WIDTH-1:0]     SrcA,
    input  logic [DATA_WIDTH-1:0]     SrcB,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     ALUResult,
    output logic                      Zero,
    output logic                      LtS,
    output logic                      LtU,
    output logic                      illegal
);

    localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD   = ALU_CTRL_WIDTH'(4'b0000);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB   = ALU_CTRL_WIDTH'(4'b0001);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLL   = ALU_CTRL_WIDTH'(4'b0010);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLT   = ALU_CTRL_WIDTH'(4'b0011);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLTU  = ALU_CTRL_WIDTH'(4'b0100);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR   = ALU_CTRL_WIDTH'(4'b0101);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRL   = ALU_CTRL_WIDTH'(4'b0110);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRA   = ALU_CTRL_WIDTH'(4'b0111);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR    = ALU_CTRL_WIDTH'(4'b1000);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND   = ALU_CTRL_WIDTH'(4'b1001);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_AUIPC = ALU_CTRL_WIDTH'(4'b1010);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_LUI   = ALU_CTRL_WIDTH'(4'b1011);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_LINK  = ALU_CTRL_WIDTH'(4'b1100);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_r;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   result_r;
    logic                    zero_r;
    logic                    lts_r;
    logic                    ltu_r;
    logic                    illegal_r;

    logic [SHAMT_WIDTH-1:0]  shamt_s;
    logic [DATA_WIDTH-1:0]   sum_s;
    logic [DATA_WIDTH-1:0]   result_s;
    logic                    lts_s;
    logic                    ltu_s;
    logic                    illegal_s;
    logic                    in_ready_s;
    logic                    capture_s;

    // Operand-only comparisons and shared adder/shift amount.
    always_comb begin
        shamt_s = SrcB[SHAMT_WIDTH-1:0];
        sum_s   = SrcA + SrcB;
        lts_s   = ($signed(SrcA) < $signed(SrcB));
        ltu_s   = (SrcA < SrcB);
    end

    // Result mux decoded from ALUControl; undefined codes yield zero and flag illegal.
    always_comb begin
        result_s  = {DATA_WIDTH{1'b0}};
        illegal_s = 1'b0;
        case (ALUControl)
            OP_ADD:   result_s = sum_s;
            OP_SUB:   result_s = SrcA - SrcB;
            OP_SLL:   result_s = SrcA << shamt_s;
            OP_SLT:   result_s = {{(DATA_WIDTH-1){1'b0}}, lts_s};
            OP_SLTU:  result_s = {{(DATA_WIDTH-1){1'b0}}, ltu_s};
            OP_XOR:   result_s = SrcA ^ SrcB;
            OP_SRL:   result_s = SrcA >> shamt_s;
            OP_SRA:   result_s = $unsigned($signed(SrcA) >>> shamt_s);
            OP_OR:    result_s = SrcA | SrcB;
            OP_AND:   result_s = SrcA & SrcB;
            OP_AUIPC: result_s = sum_s;
            OP_LUI:   result_s = SrcB;
            OP_LINK:  result_s = SrcA + DATA_WIDTH'(4);
            default: begin
                result_s  = {DATA_WIDTH{1'b0}};
                illegal_s = 1'b1;
            end
        endcase
    end

    // Handshake: the slot is free when empty or when its content leaves this cycle.
    always_comb begin
        in_ready_s = !out_valid_r || out_ready;
        capture_s  = in_valid && in_ready_s && !flush;
    end

    // Occupancy FSM; flush empties the slot regardless of the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (capture_s) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (capture_s || !out_ready) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Result fields load only on capture, so they hold through back-pressure and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r  <= {DATA_WIDTH{1'b0}};
            zero_r    <= 1'b0;
            lts_r     <= 1'b0;
            ltu_r     <= 1'b0;
            illegal_r <= 1'b0;
        end else if (capture_s) begin
            result_r  <= result_s;
            zero_r    <= (result_s == {DATA_WIDTH{1'b0}});
            lts_r     <= lts_s;
            ltu_r     <= ltu_s;
            illegal_r <= illegal_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign ALUResult = result_r;
    assign Zero      = zero_r;
    assign LtS       = lts_r;
    assign LtU       = ltu_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + short random bench for alu_exec_stage with a result scoreboard queue.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        LtS;
    logic        LtU;
    logic        illegal;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        lts;
        logic        ltu;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    logic model_full;
    int   tests;
    int   fails;

    alu_exec_stage #(
        .DATA_WIDTH(32), .ALU_CTRL_WIDTH(4), .SHAMT_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
        .Zero(Zero), .LtS(LtS), .LtU(LtU), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [4:0] s;
        logic slt_v;
        s       = b[4:0];
        slt_v   = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
        e.ill   = 1'b0;
        e.res   = 32'h0;
        case (c)
            4'd0:  e.res = a + b;
            4'd1:  e.res = a + ~b + 32'd1;
            4'd2:  e.res = a << s;
            4'd3:  e.res = slt_v ? 32'd1 : 32'd0;
            4'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd5:  e.res = a ^ b;
            4'd6:  e.res = a >> s;
            4'd7:  e.res = a[31] ? ((a >> s) | ~(32'hFFFF_FFFF >> s)) : (a >> s);
            4'd8:  e.res = a | b;
            4'd9:  e.res = a & b;
            4'd10: e.res = a + b;
            4'd11: e.res = b;
            4'd12: e.res = a + 32'd4;
            default: begin
                e.res = 32'h0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'h0);
        e.lts  = slt_v;
        e.ltu  = (a < b);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check before the posedge, update the model after it.
    task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy, input logic fl);
        logic exp_rdy;
        logic cap;
        in_valid   = v;
        ALUControl = c;
        SrcA       = a;
        SrcB       = b;
        out_ready  = ordy;
        flush      = fl;
        #2;
        exp_rdy = !model_full || ordy;
        chk("out_valid", {31'b0, out_valid}, {31'b0, model_full});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        if (model_full) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL scoreboard_empty: observed %0d entries expected 1", sb.size());
            end
            if (sb.size() != 0) begin
                chk("ALUResult", ALUResult, sb[0].res);
                chk("Zero", {31'b0, Zero}, {31'b0, sb[0].zero});
                chk("LtS", {31'b0, LtS}, {31'b0, sb[0].lts});
                chk("LtU", {31'b0, LtU}, {31'b0, sb[0].ltu});
                chk("illegal", {31'b0, illegal}, {31'b0, sb[0].ill});
                if (ordy && !fl) void'(sb.pop_front());
            end
        end
        if (fl) sb.delete();
        cap = v && exp_rdy && !fl;
        if (cap) sb.push_back(model(c, a, b));
        @(posedge clk);
        if (fl)         model_full = 1'b0;
        else if (cap)   model_full = 1'b1;
        else if (ordy)  model_full = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        model_full = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        ALUControl = 4'h0;
        SrcA       = 32'h0;
        SrcB       = 32'h0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ALUResult", ALUResult, 32'h0);
        chk("rst_Zero", {31'b0, Zero}, 32'd0);
        chk("rst_LtS", {31'b0, LtS}, 32'd0);
        chk("rst_LtU", {31'b0, LtU}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // sub 5-5
        step(1'b1, 4'b0001, 32'd5, 32'd5, 1'b1, 1'b0);
        chk("sub_result", ALUResult, 32'h0);
        chk("sub_zero", {31'b0, Zero}, 32'd1);

        // sra then srl of 0x80000000 by 4 (upper B bits ignored)
        step(1'b1, 4'b0111, 32'h8000_0000, 32'h0000_0024, 1'b1, 1'b0);
        chk("sra_result", ALUResult, 32'hF800_0000);
        step(1'b1, 4'b0110, 32'h8000_0000, 32'h0000_0024, 1'b1, 1'b0);
        chk("srl_result", ALUResult, 32'h0800_0000);

        // slt / sltu with -1 vs 1
        step(1'b1, 4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        chk("slt_result", ALUResult, 32'd1);
        chk("slt_LtS", {31'b0, LtS}, 32'd1);
        step(1'b1, 4'b0100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        chk("sltu_result", ALUResult, 32'd0);
        chk("sltu_LtU", {31'b0, LtU}, 32'd0);

        // back-pressure: add 2+3 held for 3 cycles, then replaced by lui
        step(1'b1, 4'b0000, 32'd2, 32'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0101, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0);
            chk("bp_hold_result", ALUResult, 32'd5);
        end
        step(1'b1, 4'b1011, 32'h0, 32'h1234_5000, 1'b1, 1'b0);
        chk("lui_result", ALUResult, 32'h1234_5000);
        chk("lui_out_valid", {31'b0, out_valid}, 32'd1);

        // flush after capturing a link op
        step(1'b1, 4'b1100, 32'h0000_0100, 32'h0, 1'b1, 1'b0);
        chk("link_result", ALUResult, 32'h0000_0104);
        step(1'b1, 4'b0000, 32'd7, 32'd7, 1'b0, 1'b1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);

        // illegal code, then asynchronous reset while full
        step(1'b1, 4'b1110, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        chk("ill_result", ALUResult, 32'h0);
        chk("ill_flag", {31'b0, illegal}, 32'd1);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_illegal", {31'b0, illegal}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        model_full = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // short random mix; flush only while downstream is stalled
        for (int i = 0; i < 40; i++) begin
            logic ordy_v;
            logic fl_v;
            ordy_v = ($urandom_range(0, 3) != 0);
            fl_v   = !ordy_v && ($urandom_range(0, 4) == 0);
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 $urandom, $urandom, ordy_v, fl_v);
        end
        step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
